// File: rtl/multicycle_control_fsm.sv
// Multi-cycle Moore control sequencer for the MIPS-subset datapath (R, lw, sw, beq, j).
// Define ILLEGAL_OP_TRAP_EN to park the FSM in TRAP on an illegal opcode.
module multicycle_control_fsm #(
  parameter int CNT_W        = 32,
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             mem_to_reg,
  output logic             reg_dst,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_source,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] instr_retired,
  output logic             mem_timeout,
  output logic             trap
);

  localparam int WW = (MEM_WAIT_MAX < 2) ? 1 : $clog2(MEM_WAIT_MAX + 1);
  localparam logic [WW-1:0] WMAX = WW'(MEM_WAIT_MAX);

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_J   = 6'b000010;

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEM_ADDR  = 4'd2,
    MEM_READ  = 4'd3,
    MEM_WB    = 4'd4,
    MEM_WRITE = 4'd5,
    R_EXEC    = 4'd6,
    R_WB      = 4'd7,
    BRANCH    = 4'd8,
    JUMP      = 4'd9
`ifdef ILLEGAL_OP_TRAP_EN
    , TRAP    = 4'd10
`endif
  } state_t;

  state_t cur, nxt;
  logic [WW-1:0] wcnt;
  logic retire, stall;

  assign state = cur;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur           <= FETCH;
      instr_retired <= '0;
      mem_timeout   <= 1'b0;
      wcnt          <= '0;
    end else begin
      cur <= nxt;
      if (retire) instr_retired <= instr_retired + CNT_W'(1);
      if (wcnt == WMAX) mem_timeout <= 1'b1;
      if (stall) wcnt <= (wcnt == WMAX) ? wcnt : wcnt + WW'(1);
      else wcnt <= '0;
    end
  end

  always_comb begin
    nxt           = cur;
    retire        = 1'b0;
    stall         = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_source     = 2'b00;
    trap          = 1'b0;
    unique case (cur)
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        stall     = !mem_ready;
        if (mem_ready) nxt = DECODE;
      end
      DECODE: begin
        alu_src_b = 2'b11;
        unique case (1'b1)
          opcode == OP_R:   nxt = R_EXEC;
          opcode == OP_LW,
          opcode == OP_SW:  nxt = MEM_ADDR;
          opcode == OP_BEQ: nxt = BRANCH;
          opcode == OP_J:   nxt = JUMP;
`ifdef ILLEGAL_OP_TRAP_EN
          default:          nxt = TRAP;
`else
          default:          nxt = FETCH;
`endif
        endcase
      end
      MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        nxt = (opcode == OP_SW) ? MEM_WRITE : MEM_READ;
      end
      MEM_READ: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        stall    = !mem_ready;
        if (mem_ready) nxt = MEM_WB;
      end
      MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        retire     = 1'b1;
        nxt        = FETCH;
      end
      MEM_WRITE: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        stall     = !mem_ready;
        if (mem_ready) begin
          retire = 1'b1;
          nxt    = FETCH;
        end
      end
      R_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        nxt       = R_WB;
      end
      R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        retire    = 1'b1;
        nxt       = FETCH;
      end
      BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        retire        = 1'b1;
        nxt           = FETCH;
      end
      JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
        retire    = 1'b1;
        nxt       = FETCH;
      end
`ifdef ILLEGAL_OP_TRAP_EN
      TRAP: trap = 1'b1;
`endif
      default: nxt = FETCH;
    endcase
    // no architectural write may slip out on a reset cycle
    if (!rst_n) begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      ir_write      = 1'b0;
      reg_write     = 1'b0;
      mem_write     = 1'b0;
    end
  end

endmodule
